mem_read_arb: RTL

MEM_READ_ARB -- requirements
Module: mem_read_arb

---
 rtl/sat_mem_pkg.sv | 19 +
 rtl/rr_arb2.sv | 37 +++
 rtl/mem_read_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sat_mem_pkg.sv
// Shared encodings for the memory read arbiter: FSM states, requester IDs
// and default geometry.
package sat_mem_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_LEN_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef enum logic {
        REQ_ID0 = 1'b0,
        REQ_ID1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The priority pointer names the requester that
// wins a tie; after every grant it moves to the requester that lost.
module rr_arb2
    import sat_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       win_o
);

    req_id_e ptr_q;
    req_id_e win;

    always_comb begin
        win = REQ_ID0;
        if (req_i == 2'b11) begin
            win = ptr_q;
        end else if (req_i[1]) begin
            win = REQ_ID1;
        end
    end

    assign win_o = (win == REQ_ID1);
    assign gnt_o = (en_i && (req_i != 2'b00)) ? ((win == REQ_ID1) ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= REQ_ID0;
        end else if (gnt_o != 2'b00) begin
            ptr_q <= (win == REQ_ID1) ? REQ_ID0 : REQ_ID1;
        end
    end

endmodule

// File: rtl/mem_read_arb.sv
// Arbitrates two read-burst requesters onto one synchronous-read memory and
// routes each returned word to the requester that owns the read.
//
// state    | meaning
// ST_IDLE  | no burst open; arbiter may accept and issue the first read
// ST_BURST | issuing the remaining reads of the owner's burst, one per cycle
module mem_read_arb
    import sat_mem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]  req0_len,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]  req1_len,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp0_last,
    output logic              rsp1_valid,
    output logic              rsp1_last,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    input  logic [WIDTH-1:0]  mem_data_i
);

    state_e            state_q, state_d;
    req_id_e           owner_q, owner_d, rd_id;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
    logic [LEN_W-1:0]  rem_q, rem_d, win_len;
    logic [1:0]        gnt;
    logic [1:0]        rsp_vld_q;
    logic              win, issue, rd_last, rsp_last_q;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == ST_IDLE),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt),
        .win_o (win)
    );

    // rem_q counts reads still to issue after the one in flight this cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        issue   = 1'b0;
        rd_id   = owner_q;
        rd_addr = '0;
        rd_last = 1'b0;
        win_len = win ? req1_len : req0_len;
        if (state_q == ST_IDLE) begin
            if (gnt != 2'b00) begin
                issue   = 1'b1;
                rd_id   = win ? REQ_ID1 : REQ_ID0;
                rd_addr = win ? req1_addr : req0_addr;
                rd_last = (win_len == '0);
                if (win_len != '0) begin
                    state_d = ST_BURST;
                    owner_d = rd_id;
                    addr_d  = wrap_inc(rd_addr);
                    rem_d   = win_len;
                end
            end
        end else begin
            issue   = 1'b1;
            rd_addr = addr_q;
            rd_last = (rem_q == LEN_W'(1));
            addr_d  = wrap_inc(addr_q);
            rem_d   = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= REQ_ID0;
            addr_q     <= '0;
            rem_q      <= '0;
            rsp_vld_q  <= 2'b00;
            rsp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rsp_vld_q  <= issue ? ((rd_id == REQ_ID1) ? 2'b10 : 2'b01) : 2'b00;
            rsp_last_q <= issue & rd_last;
        end
    end

    // Everything is gated by rst_n so outputs drop as soon as reset asserts.
    assign req0_ready  = gnt[0] & rst_n;
    assign req1_ready  = gnt[1] & rst_n;
    assign mem_read_en = issue & rst_n;
    assign mem_addr    = (issue && rst_n) ? rd_addr : '0;
    assign rsp0_valid  = rsp_vld_q[0] & rst_n;
    assign rsp1_valid  = rsp_vld_q[1] & rst_n;
    assign rsp0_last   = rsp_vld_q[0] & rsp_last_q & rst_n;
    assign rsp1_last   = rsp_vld_q[1] & rsp_last_q & rst_n;
    assign rsp_data    = mem_data_i;

endmodule
